// File: rtl/uart_sched_pkg.sv
// Shared types and default parameter values for the UART TX scheduler.
// C_TIMEOUT only exists when UART_SCHED_TIMEOUT_EN is defined.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } t_sched_state;

  localparam int C_NB_REQ     = 4;
  localparam int C_DATA_WIDTH = 8;
  localparam int C_MAX_BURST  = 16;
  localparam int C_GAP_CYCLES = 2;
`ifdef UART_SCHED_TIMEOUT_EN
  localparam int C_TIMEOUT    = 4096;
`endif

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester bus plus TX engine start/done handshake of the UART TX scheduler.
// master = requesters and TX engine side, slave = scheduler side.
interface uart_tx_scheduler_if #(
  parameter int G_NB_REQ     = 4,
  parameter int G_DATA_WIDTH = 8
);

  logic [G_NB_REQ-1:0]              i_req;
  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data;
  logic [G_NB_REQ-1:0]              i_last;
  logic [G_NB_REQ-1:0]              o_ack;
  logic                             o_tx_start;
  logic [G_DATA_WIDTH-1:0]          o_tx_data;
  logic                             i_tx_done;
  logic [$clog2(G_NB_REQ)-1:0]      o_grant_id;
  logic                             o_busy;
  logic                             o_timeout;

  modport master (
    output i_req, i_data, i_last, i_tx_done,
    input  o_ack, o_tx_start, o_tx_data, o_grant_id, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_data, i_last, i_tx_done,
    output o_ack, o_tx_start, o_tx_data, o_grant_id, o_busy, o_timeout
  );

endinterface

// File: rtl/uart_sched_rr_arb.sv
// Combinational round-robin pick: first requesting index after ptr, wrapping,
// so ptr itself has the lowest priority.
module uart_sched_rr_arb #(
  parameter int  G_NB_REQ = 4,
  localparam int C_ID_W   = $clog2(G_NB_REQ)
) (
  input  logic [G_NB_REQ-1:0] req,
  input  logic [C_ID_W-1:0]   ptr,
  output logic [C_ID_W-1:0]   grant,
  output logic                valid
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = G_NB_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % G_NB_REQ]) begin
        grant = C_ID_W'((int'(ptr) + i) % G_NB_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, burst-granular sharing of one UART TX engine between requesters.
// Optional TX watchdog enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int G_NB_REQ     = C_NB_REQ,
  parameter int G_DATA_WIDTH = C_DATA_WIDTH,
  parameter int G_MAX_BURST  = C_MAX_BURST,
`ifdef UART_SCHED_TIMEOUT_EN
  parameter int G_TIMEOUT    = C_TIMEOUT,
`endif
  parameter int G_GAP_CYCLES = C_GAP_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_scheduler_if.slave bus
);

  localparam int C_ID_W    = $clog2(G_NB_REQ);
  localparam int C_BURST_W = $clog2(G_MAX_BURST + 1);
  localparam int C_GAP_W   = $clog2(G_GAP_CYCLES + 1);

  t_sched_state            state_q, state_d;
  logic [C_ID_W-1:0]       grant_id_q, grant_id_d;
  logic [G_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                    last_q, last_d;
  logic [C_BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [C_GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                    tx_start_q, tx_start_d;
  logic [G_NB_REQ-1:0]     ack_q, ack_d;
  logic                    busy_q, busy_d;
`ifdef UART_SCHED_TIMEOUT_EN
  localparam int C_TMO_W = $clog2(G_TIMEOUT + 1);
  logic [C_TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  logic                    arb_valid;
  logic [C_ID_W-1:0]       arb_grant;
  logic [C_ID_W-1:0]       cap_id;
  logic                    capture;

  // grant_id_q doubles as the round-robin pointer: it holds the last owner while idle.
  uart_sched_rr_arb #(.G_NB_REQ(G_NB_REQ)) u_arb (
    .req   (bus.i_req),
    .ptr   (grant_id_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign cap_id = (state_q == S_IDLE) ? arb_grant : grant_id_q;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_start_d  = 1'b0;
    ack_d       = '0;
    capture     = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: capture = arb_valid;
      S_START: begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        state_d     = S_WAIT;
`ifdef UART_SCHED_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.i_tx_done) begin
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == C_TMO_W'(G_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          last_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == C_GAP_W'(G_GAP_CYCLES - 1)) begin
          if (!last_q && (burst_cnt_q < C_BURST_W'(G_MAX_BURST)) && bus.i_req[grant_id_q]) begin
            capture = 1'b1;
          end else begin
            burst_cnt_d = '0;
            state_d     = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Start and ack are registered so both are high for exactly the S_START cycle.
    if (capture) begin
      grant_id_d    = cap_id;
      tx_data_d     = bus.i_data[int'(cap_id)*G_DATA_WIDTH +: G_DATA_WIDTH];
      last_d        = bus.i_last[cap_id];
      tx_start_d    = 1'b1;
      ack_d[cap_id] = 1'b1;
      state_d       = S_START;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      tx_start_q  <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_start_q  <= tx_start_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
`ifdef UART_SCHED_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_grant_id = grant_id_q;
  assign bus.o_busy     = busy_q;
`ifdef UART_SCHED_TIMEOUT_EN
  assign bus.o_timeout  = timeout_q;
`else
  assign bus.o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester queues and a TX engine model feed a
// scoreboard of expected {owner, byte} frames checked at every o_tx_start.
module tb_uart_tx_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } sb_entry_t;

  logic clk;
  logic rst_n;

  uart_tx_scheduler_if #(.G_NB_REQ(4), .G_DATA_WIDTH(8)) bus ();

`ifdef UART_SCHED_TIMEOUT_EN
  uart_tx_scheduler #(.G_TIMEOUT(64)) dut (
`else
  uart_tx_scheduler dut (
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int        check_count = 0;
  int        pass_count  = 0;
  sb_entry_t sb_q[$];
  logic [8:0] req_mem[4][64];
  int        req_head[4];
  int        req_tail[4];
  int        tx_delay    = 0;
  bit        tx_auto     = 1'b1;
  bit        late_done   = 1'b0;
  int        start_count = 0;
  int        done_count  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int k, input logic [7:0] d, input logic last);
    req_mem[k][req_tail[k]] = {last, d};
    req_tail[k]++;
  endtask

  task automatic expectFrame(input int k, input logic [7:0] d);
    sb_entry_t e;
    e.id   = 2'(k);
    e.data = d;
    sb_q.push_back(e);
  endtask

  function automatic bit allIdle();
    bit idle;
    idle = (sb_q.size() == 0) && !bus.o_busy && (tx_delay == 0);
    for (int k = 0; k < 4; k++) if (req_head[k] != req_tail[k]) idle = 1'b0;
    return idle;
  endfunction

  task automatic waitDrain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #1;
      done = allIdle();
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic waitStart(input string tag, input int budget);
    int s0;
    bit seen;
    s0   = start_count;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk); #1;
      seen = (start_count != s0);
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  // Requester and TX engine model: frame check at each start, pops on ack.
  initial begin
    sb_entry_t e;
    bus.i_req     = '0;
    bus.i_data    = '0;
    bus.i_last    = '0;
    bus.i_tx_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_head[k] = 0;
      req_tail[k] = 0;
    end
    forever begin
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (bus.o_tx_start) begin
        start_count++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("tx_data", 32'(bus.o_tx_data), 32'(e.data));
          checkOutput("grant_id", 32'(bus.o_grant_id), 32'(e.id));
          checkOutput("ack", 32'(bus.o_ack), 32'd1 << e.id);
        end
        tx_delay = tx_auto ? 3 : 0;
      end else if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) begin
          bus.i_tx_done = 1'b1;
          done_count++;
        end
      end else if (late_done) begin
        bus.i_tx_done = 1'b1;
        late_done     = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.o_ack[k] && (req_head[k] != req_tail[k])) req_head[k]++;
        bus.i_req[k]          = (req_head[k] != req_tail[k]);
        bus.i_data[k*8 +: 8]  = req_mem[k][req_head[k]][7:0];
        bus.i_last[k]         = req_mem[k][req_head[k]][8];
      end
    end
  end

  initial begin
    int d0;
    int n;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    checkOutput("rst_ack", 32'(bus.o_ack), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.o_grant_id), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    checkOutput("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst_n = 1'b1;

    $display("[TB] T1 single byte");
    applyStimulus(2, 8'hA5, 1'b1);
    expectFrame(2, 8'hA5);
    @(negedge clk); #1;
    checkOutput("t1_no_start_yet", 32'(bus.o_tx_start), 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_latency", 32'(bus.o_tx_start), 32'd1);
    checkOutput("t1_busy", 32'(bus.o_busy), 32'd1);
    d0   = done_count;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      seen = (done_count != d0);
    end
    checkOutput("t1_done_seen", 32'(seen), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("t1_gap_busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk); #1;
    checkOutput("t1_idle", 32'(bus.o_busy), 32'd0);
    checkOutput("t1_grant_kept", 32'(bus.o_grant_id), 32'd2);
    waitDrain("t1_drain", 50);

    $display("[TB] T2 contention from pointer 0");
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(k, 8'h10 + 8'(k), 1'b1);
    expectFrame(1, 8'h11);
    expectFrame(2, 8'h12);
    expectFrame(3, 8'h13);
    expectFrame(0, 8'h10);
    waitDrain("t2_drain", 200);

    $display("[TB] T3 burst lock");
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b1);
    expectFrame(0, 8'h11);
    expectFrame(0, 8'h22);
    expectFrame(0, 8'h33);
    expectFrame(1, 8'h44);
    waitStart("t3_first_start", 20);
    applyStimulus(1, 8'h44, 1'b1);
    waitDrain("t3_drain", 300);

    $display("[TB] T4 fairness release after max burst");
    for (int i = 0; i < 20; i++) applyStimulus(0, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) expectFrame(0, 8'h40 + 8'(i));
    expectFrame(1, 8'h99);
    for (int i = 16; i < 20; i++) expectFrame(0, 8'h40 + 8'(i));
    waitStart("t4_first_start", 20);
    applyStimulus(1, 8'h99, 1'b1);
    waitDrain("t4_drain", 1000);

    $display("[TB] T5 reset during wait");
    tx_auto = 1'b0;
    applyStimulus(3, 8'h5A, 1'b1);
    expectFrame(3, 8'h5A);
    waitStart("t5_start", 20);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("t5_busy_in_wait", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checkOutput("t5_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("t5_tx_data", 32'(bus.o_tx_data), 32'd0);
    checkOutput("t5_grant_id", 32'(bus.o_grant_id), 32'd0);
    checkOutput("t5_ack", 32'(bus.o_ack), 32'd0);
    rst_n     = 1'b1;
    late_done = 1'b1;
    d0 = start_count;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t5_late_done_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("t5_no_restart", 32'(start_count), 32'(d0));
    tx_auto = 1'b1;

`ifdef UART_SCHED_TIMEOUT_EN
    $display("[TB] T6 watchdog");
    tx_auto = 1'b0;
    applyStimulus(2, 8'hC3, 1'b1);
    applyStimulus(3, 8'h3C, 1'b1);
    expectFrame(2, 8'hC3);
    expectFrame(3, 8'h3C);
    waitStart("t6_start", 20);
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk); #1;
      n++;
      seen = bus.o_timeout;
    end
    checkOutput("t6_timeout_cycle", 32'(n), 32'd65);
    tx_auto = 1'b1;
    @(negedge clk); #1;
    checkOutput("t6_timeout_pulse", 32'(bus.o_timeout), 32'd0);
    waitDrain("t6_drain", 200);
`endif

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
